// File: rtl/data_mem_port_pkg.sv
// Shared ISA definitions for the MEM-stage load/store port: opcode values and
// opcode decode helpers used by the FSM and the lane formatter.
package data_mem_port_pkg;

  localparam logic [5:0] OPC_LB = 6'h20;
  localparam logic [5:0] OPC_LW = 6'h23;
  localparam logic [5:0] OPC_SB = 6'h28;
  localparam logic [5:0] OPC_SW = 6'h2B;

  function automatic logic [5:0] get_opc(input logic [31:0] insn);
    return insn[31:26];
  endfunction

  function automatic logic is_mem_opc(input logic [5:0] opc);
    return (opc == OPC_LB) || (opc == OPC_LW) || (opc == OPC_SB) || (opc == OPC_SW);
  endfunction

  function automatic logic is_word_opc(input logic [5:0] opc);
    return (opc == OPC_LW) || (opc == OPC_SW);
  endfunction

  function automatic logic is_store_opc(input logic [5:0] opc);
    return (opc == OPC_SB) || (opc == OPC_SW);
  endfunction

endpackage

// File: rtl/data_mem_port_lane_formatter.sv
// Byte-lane steering for stores (byte enables, replicated data) and load
// extraction with sign extension for LB. Purely combinational.
module lane_formatter
  import data_mem_port_pkg::*;
(
  input  logic [5:0]  opc,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0] byte_lane;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
    be        = 4'hF;
    wdata     = store_data;
    load_data = rdata;
    byte_lane = rdata[8*byte_sel +: 8];
    case (opc)
      OPC_SB: begin
        be    = 4'b0001 << byte_sel;
        wdata = {4{store_data[7:0]}};
      end
      OPC_LB:  load_data = {{24{byte_lane[7]}}, byte_lane};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_port.sv
// MEM-stage load/store engine: issues LB/LW/SB/SW on a grant/valid memory bus,
// stalls the pipeline while the access is outstanding, and returns load data.
module data_mem_port
  import data_mem_port_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              exValid,
  input  logic [31:0]       instruction,
  input  logic [31:0]       aluOut,
  input  logic [31:0]       storeData,
  output logic              stall,
  output logic              done,
  output logic [31:0]       memoryOut,
  output logic              alignErr,
  output logic              busErr,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [3:0]        memBe,
  output logic [31:0]       memWdata,
  input  logic              memGnt,
  input  logic              memRvalid,
  input  logic [31:0]       memRdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam int             CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       opc_q;
  logic [1:0]       addr_q;

  logic [5:0]  live_opc;
  logic        live_mem;
  logic        live_misaligned;
  logic [5:0]  fmt_opc;
  logic [1:0]  fmt_sel;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_load;
  logic        timeout;

  assign live_opc        = get_opc(instruction);
  assign live_mem        = exValid && is_mem_opc(live_opc);
  assign live_misaligned = is_word_opc(live_opc) && (aluOut[1:0] != 2'b00);
  assign timeout         = (cnt == CNT_LAST);

  // In IDLE the formatter sees the incoming instruction (store lanes are latched
  // on accept); afterwards it sees the latched access for load formatting.
  assign fmt_opc = (state == S_IDLE) ? live_opc    : opc_q;
  assign fmt_sel = (state == S_IDLE) ? aluOut[1:0] : addr_q;

  lane_formatter u_lane_formatter (
    .opc        (fmt_opc),
    .byte_sel   (fmt_sel),
    .store_data (storeData),
    .rdata      (memRdata),
    .be         (fmt_be),
    .wdata      (fmt_wdata),
    .load_data  (fmt_load)
  );

  assign stall = (state == S_REQ) || (state == S_WAIT) ||
                 ((state == S_IDLE) && live_mem && !live_misaligned);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      opc_q     <= '0;
      addr_q    <= '0;
      done      <= 1'b0;
      alignErr  <= 1'b0;
      busErr    <= 1'b0;
      memoryOut <= '0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memBe     <= '0;
      memWdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (live_mem) begin
            opc_q    <= live_opc;
            addr_q   <= aluOut[1:0];
            memAddr  <= {aluOut[ADDR_W-1:2], 2'b00};
            memBe    <= fmt_be;
            memWdata <= fmt_wdata;
            memWe    <= is_store_opc(live_opc);
            cnt      <= '0;
            if (live_misaligned) begin
              state    <= S_DONE;
              done     <= 1'b1;
              alignErr <= 1'b1;
            end else begin
              state  <= S_REQ;
              memReq <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (memGnt) begin
            memReq <= 1'b0;
            if (is_store_opc(opc_q)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (memRvalid) begin
              memoryOut <= fmt_load;
              state     <= S_DONE;
              done      <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= cnt + 1'b1;
            end
          end else if (timeout) begin
            memReq    <= 1'b0;
            memoryOut <= '0;
            busErr    <= 1'b1;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT: begin
          if (memRvalid) begin
            memoryOut <= fmt_load;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (timeout) begin
            memoryOut <= '0;
            busErr    <= 1'b1;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DONE: begin
          done     <= 1'b0;
          alignErr <= 1'b0;
          busErr   <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: loads, byte lanes, stores, misalignment,
// bus timeout and asynchronous reset mid-access.
module tb_data_mem_port;

  localparam int TIMEOUT = 16;
  localparam logic [31:0] INSN_LB  = 32'h8000_0000;
  localparam logic [31:0] INSN_LW  = 32'h8C00_0000;
  localparam logic [31:0] INSN_SB  = 32'hA000_0000;
  localparam logic [31:0] INSN_SW  = 32'hAC00_0000;
  localparam logic [31:0] INSN_ADD = 32'h0000_0020;

  logic        clk;
  logic        reset_n;
  logic        exValid;
  logic [31:0] instruction;
  logic [31:0] aluOut;
  logic [31:0] storeData;
  logic        stall;
  logic        done;
  logic [31:0] memoryOut;
  logic        alignErr;
  logic        busErr;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWdata;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;

  int total = 0;
  int bad   = 0;

  data_mem_port #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .exValid     (exValid),
    .instruction (instruction),
    .aluOut      (aluOut),
    .storeData   (storeData),
    .stall       (stall),
    .done        (done),
    .memoryOut   (memoryOut),
    .alignErr    (alignErr),
    .busErr      (busErr),
    .memReq      (memReq),
    .memWe       (memWe),
    .memAddr     (memAddr),
    .memBe       (memBe),
    .memWdata    (memWdata),
    .memGnt      (memGnt),
    .memRvalid   (memRvalid),
    .memRdata    (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; exValid = 1'b0; instruction = '0; aluOut = '0; storeData = '0;
    memGnt = 1'b0; memRvalid = 1'b0; memRdata = '0;
    step();
    check("rst_memReq", 32'(memReq), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_memoryOut", memoryOut, 32'h0);
    check("rst_memAddr", memAddr, 32'h0);
    check("rst_memBe", 32'(memBe), 32'h0);
    check("rst_memWdata", memWdata, 32'h0);
    check("rst_flags", {30'd0, alignErr, busErr}, 32'd0);
    reset_n = 1'b1;
    step();

    // 1: LW 0x100, grant at +1, rvalid at +2
    exValid = 1'b1; instruction = INSN_LW; aluOut = 32'h100; #1;
    check("lw_stall_c0", 32'(stall), 32'd1);
    step();
    exValid = 1'b0; memGnt = 1'b1; #1;
    check("lw_memReq_c1", 32'(memReq), 32'd1);
    check("lw_memAddr", memAddr, 32'h100);
    check("lw_memBe", 32'(memBe), 32'hF);
    check("lw_memWe", 32'(memWe), 32'd0);
    check("lw_stall_c1", 32'(stall), 32'd1);
    step();
    memGnt = 1'b0; memRvalid = 1'b1; memRdata = 32'hDEADBEEF; #1;
    check("lw_stall_c2", 32'(stall), 32'd1);
    check("lw_done_c2", 32'(done), 32'd0);
    step();
    memRvalid = 1'b0; #1;
    check("lw_done_c3", 32'(done), 32'd1);
    check("lw_memoryOut", memoryOut, 32'hDEADBEEF);
    check("lw_stall_c3", 32'(stall), 32'd0);
    check("lw_flags", {30'd0, alignErr, busErr}, 32'd0);
    step();
    check("lw_done_pulse", 32'(done), 32'd0);

    // 2a: LB 0x203, grant and rvalid together at +1
    exValid = 1'b1; instruction = INSN_LB; aluOut = 32'h203; #1;
    step();
    exValid = 1'b0; memGnt = 1'b1; memRvalid = 1'b1; memRdata = 32'h80112233; #1;
    check("lb3_memBe", 32'(memBe), 32'hF);
    check("lb3_memAddr", memAddr, 32'h200);
    step();
    memGnt = 1'b0; memRvalid = 1'b0; #1;
    check("lb3_done", 32'(done), 32'd1);
    check("lb3_memoryOut", memoryOut, 32'hFFFFFF80);
    step();

    // 2b: LB 0x201, grant +1, rvalid +2
    exValid = 1'b1; instruction = INSN_LB; aluOut = 32'h201; #1;
    step();
    exValid = 1'b0; memGnt = 1'b1; #1;
    step();
    memGnt = 1'b0; memRvalid = 1'b1; memRdata = 32'h80112233; #1;
    step();
    memRvalid = 1'b0; #1;
    check("lb1_done", 32'(done), 32'd1);
    check("lb1_memoryOut", memoryOut, 32'h00000022);
    step();

    // 3: SB 0x302
    exValid = 1'b1; instruction = INSN_SB; aluOut = 32'h302; storeData = 32'h000000A5; #1;
    check("sb_stall_c0", 32'(stall), 32'd1);
    step();
    exValid = 1'b0; storeData = 32'h0; memGnt = 1'b1; #1;
    check("sb_memReq", 32'(memReq), 32'd1);
    check("sb_memWe", 32'(memWe), 32'd1);
    check("sb_memBe", 32'(memBe), 32'b0100);
    check("sb_memWdata", memWdata, 32'hA5A5A5A5);
    check("sb_memAddr", memAddr, 32'h300);
    step();
    memGnt = 1'b0; #1;
    check("sb_done", 32'(done), 32'd1);
    check("sb_memReq_off", 32'(memReq), 32'd0);
    check("sb_memoryOut_held", memoryOut, 32'h00000022);
    step();

    // 4: SW 0x006 misaligned
    exValid = 1'b1; instruction = INSN_SW; aluOut = 32'h006; storeData = 32'h12345678; #1;
    check("sw_mis_stall_c0", 32'(stall), 32'd0);
    step();
    exValid = 1'b0; #1;
    check("sw_mis_done", 32'(done), 32'd1);
    check("sw_mis_alignErr", 32'(alignErr), 32'd1);
    check("sw_mis_memReq", 32'(memReq), 32'd0);
    check("sw_mis_stall_c1", 32'(stall), 32'd0);
    step();
    check("sw_mis_clear", {30'd0, done, alignErr}, 32'd0);

    // 5: LW with no grant -> timeout
    exValid = 1'b1; instruction = INSN_LW; aluOut = 32'h040; #1;
    step();
    exValid = 1'b0; #1;
    repeat (TIMEOUT - 1) step();
    check("to_memReq_last", 32'(memReq), 32'd1);
    check("to_done_early", 32'(done), 32'd0);
    step();
    check("to_done", 32'(done), 32'd1);
    check("to_busErr", 32'(busErr), 32'd1);
    check("to_memReq_off", 32'(memReq), 32'd0);
    check("to_memoryOut", memoryOut, 32'h0);
    step();
    check("to_clear", {29'd0, memReq, done, busErr}, 32'd0);

    // 6: reset in WAIT, stray rvalid ignored, ADD does not stall
    exValid = 1'b1; instruction = INSN_LW; aluOut = 32'h080; #1;
    step();
    exValid = 1'b0; memGnt = 1'b1; #1;
    step();
    memGnt = 1'b0; #1;
    check("rstw_stall_before", 32'(stall), 32'd1);
    reset_n = 1'b0; #1;
    check("rstw_memReq", 32'(memReq), 32'd0);
    check("rstw_stall", 32'(stall), 32'd0);
    check("rstw_done", 32'(done), 32'd0);
    step();
    reset_n = 1'b1; memRvalid = 1'b1; memRdata = 32'hCAFEF00D; #1;
    step();
    memRvalid = 1'b0; #1;
    check("rstw_rvalid_done", 32'(done), 32'd0);
    check("rstw_rvalid_memoryOut", memoryOut, 32'h0);
    exValid = 1'b1; instruction = INSN_ADD; aluOut = 32'h100; #1;
    check("add_stall", 32'(stall), 32'd0);
    step();
    exValid = 1'b0; #1;
    check("add_memReq", 32'(memReq), 32'd0);
    check("add_done", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
